// File: rtl/core_pkg.sv
// Shared constants for the RV32I multi-cycle sequencer: opcodes, FSM state
// encoding, trap causes, the reset IR value and small opcode classifiers.
// Latency: n/a (constants and pure functions). Backpressure: n/a.
package core_pkg;

  // Major opcodes, IR[6:0]
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // FSM state encoding (visible on out_state)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  // Trap causes
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Opcodes the datapath can execute (SYSTEM is handled separately as a trap).
  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: opc_legal = 1'b1;
      default:                                              opc_legal = 1'b0;
    endcase
  endfunction

  // Opcodes that produce a value for rd.
  function automatic logic opc_writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: opc_writes_rd = 1'b1;
      default:                      opc_writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for an outstanding memory request, shared by the fetch and data phases.
// Latency: expired rises combinationally in the TIMEOUT-th cycle of an active request.
// Backpressure: none; it only observes. Ports: clk, rst_n (sync), clear, active -> expired.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // Holds at LAST once reached; the owner leaves the phase on that cycle anyway.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (active && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // TIMEOUT == 0 disables the watchdog entirely.
  assign expired = (TIMEOUT != 0) && active && (cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with IR latch, strobes, retire count, traps.
// Latency: 4 cycles per zero-wait non-memory instruction, 5 for zero-wait load/store.
// Backpressure: imem/dmem req held until ready; a request unanswered for TIMEOUT cycles traps.
// Ports: in_clk, in_rst_n (sync, active-low); imem req/ready/rdata; dmem req/we/ready;
//        out_inst (IR), out_rf_we/out_pc_we/out_retire (WB only), out_instret, out_state, out_trap/cause.
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  output logic             out_imem_req,
  input  logic             in_imem_ready,
  input  logic [31:0]      in_imem_rdata,
  output logic             out_dmem_req,
  output logic             out_dmem_we,
  input  logic             in_dmem_ready,
  output logic [31:0]      out_inst,
  output logic             out_rf_we,
  output logic             out_pc_we,
  output logic             out_retire,
  output logic [CNT_W-1:0] out_instret,
  output logic [2:0]       out_state,
  output logic             out_trap,
  output logic [1:0]       out_trap_cause
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [31:0]      ir;
  logic [CNT_W-1:0] instret;
  logic [1:0]       cause;
  logic [1:0]       cause_nxt;
  logic [6:0]       opc;
  logic             is_mem_op;
  logic             req_active;
  logic             expired;

  assign opc        = ir[6:0];
  assign is_mem_op  = (opc == OPC_LOAD) || (opc == OPC_STORE);
  assign req_active = (state == ST_FETCH) || (state == ST_MEM);

  // Counter is held clear in every non-request state, so it starts from 0
  // on each entry into FETCH or MEM.
  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (in_clk),
    .rst_n   (in_rst_n),
    .clear   (!req_active),
    .active  (req_active),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    case (state)
      ST_FETCH: begin
        // Ready beats an expiring watchdog in the same cycle.
        if (in_imem_ready) begin
          state_nxt = ST_DECODE;
        end else if (expired) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (opc == OPC_SYSTEM) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_SYSTEM;
        end else if (opc_legal(opc)) begin
          state_nxt = ST_EXEC;
        end else begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: state_nxt = is_mem_op ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (in_dmem_ready) begin
          state_nxt = ST_WB;
        end else if (expired) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_DMEM_TO;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_TRAP: state_nxt = ST_TRAP;
      // Encodings 5/6 are unreachable; recover by refetching.
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state   <= ST_FETCH;
      ir      <= NOP_INST;
      instret <= '0;
      cause   <= CAUSE_ILLEGAL;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      if ((state == ST_FETCH) && in_imem_ready) begin
        ir <= in_imem_rdata;
      end
      // Wraps naturally at 2^CNT_W.
      if (state == ST_WB) begin
        instret <= instret + 1'b1;
      end
    end
  end

  // All requests and strobes decode from the registered state, so they are
  // glitch-free and drop in the cycle right after a reset edge.
  assign out_imem_req   = (state == ST_FETCH);
  assign out_dmem_req   = (state == ST_MEM);
  assign out_dmem_we    = (state == ST_MEM) && (opc == OPC_STORE);
  assign out_rf_we      = (state == ST_WB) && opc_writes_rd(opc);
  assign out_pc_we      = (state == ST_WB);
  assign out_retire     = (state == ST_WB);
  assign out_inst       = ir;
  assign out_instret    = instret;
  assign out_state      = state;
  assign out_trap       = (state == ST_TRAP);
  assign out_trap_cause = cause;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  localparam int TO = 4;
  localparam int CW = 8;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h00012083;
  localparam logic [31:0] SW   = 32'h00112023;

  logic          in_clk;
  logic          in_rst_n;
  logic          out_imem_req;
  logic          in_imem_ready;
  logic [31:0]   in_imem_rdata;
  logic          out_dmem_req;
  logic          out_dmem_we;
  logic          in_dmem_ready;
  logic [31:0]   out_inst;
  logic          out_rf_we;
  logic          out_pc_we;
  logic          out_retire;
  logic [CW-1:0] out_instret;
  logic [2:0]    out_state;
  logic          out_trap;
  logic [1:0]    out_trap_cause;

  core_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .out_imem_req   (out_imem_req),
    .in_imem_ready  (in_imem_ready),
    .in_imem_rdata  (in_imem_rdata),
    .out_dmem_req   (out_dmem_req),
    .out_dmem_we    (out_dmem_we),
    .in_dmem_ready  (in_dmem_ready),
    .out_inst       (out_inst),
    .out_rf_we      (out_rf_we),
    .out_pc_we      (out_pc_we),
    .out_retire     (out_retire),
    .out_instret    (out_instret),
    .out_state      (out_state),
    .out_trap       (out_trap),
    .out_trap_cause (out_trap_cause)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // One record per clock cycle: inputs to drive, outputs expected in that cycle.
  typedef struct {
    logic          rst_n;
    logic          irdy;
    logic [31:0]   rdata;
    logic          drdy;
    logic [2:0]    st;
    logic          ireq, dreq, dwe, rf, pc, ret, trap;
    logic [1:0]    cause;
    logic [31:0]   inst;
    logic [CW-1:0] instret;
  } vec_t;

  vec_t tbl[10];
  vec_t q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state at instruction granularity.
  logic [31:0]   m_ir      = NOP;
  logic [CW-1:0] m_instret = '0;
  logic [1:0]    m_cause   = 2'd0;

  function automatic vec_t mk(input logic rst_n, input logic irdy, input logic [31:0] rdata,
                              input logic drdy, input logic [2:0] st, input logic ireq,
                              input logic dreq, input logic dwe, input logic rf, input logic pc,
                              input logic ret, input logic trap, input logic [1:0] cause,
                              input logic [31:0] inst, input logic [CW-1:0] instret);
    vec_t v;
    v.rst_n = rst_n; v.irdy = irdy; v.rdata = rdata; v.drdy = drdy;
    v.st = st; v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.rf = rf; v.pc = pc;
    v.ret = ret; v.trap = trap; v.cause = cause; v.inst = inst; v.instret = instret;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic legal(input logic [6:0] o);
    return o inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                     7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
  endfunction

  function automatic logic writes_rd(input logic [6:0] o);
    return o inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                     7'b0000011, 7'b0010011, 7'b0110011};
  endfunction

  // Expected cycle in phase st: request/strobe outputs follow from the phase.
  task automatic push(input logic [2:0] st, input logic irdy, input logic [31:0] rdata,
                      input logic drdy, input logic rf, input logic dwe);
    q.push_back(mk(1'b1, irdy, rdata, drdy, st, st == S_FETCH, st == S_MEM, dwe, rf,
                   st == S_WB, st == S_WB, st == S_TRAP,
                   (st == S_TRAP) ? m_cause : 2'd0, m_ir, m_instret));
  endtask

  // Assert reset in the last queued cycle; the model then returns to its reset values.
  task automatic reset_last();
    vec_t v;
    v = q.pop_back();
    v.rst_n = 1'b0;
    q.push_back(v);
    m_ir = NOP; m_instret = '0; m_cause = 2'd0;
  endtask

  task automatic trap_then_reset(input logic [1:0] c, input int n);
    m_cause = c;
    for (int i = 0; i < n; i++) push(S_TRAP, rb(), $urandom, rb(), 1'b0, 1'b0);
    reset_last();
  endtask

  // fd/md: wait cycles before imem/dmem ready (>= TO means never answered).
  // rmem >= 0: reset after rmem unanswered MEM cycles.
  task automatic gen(input logic [31:0] inst, input int fd, input int md,
                     input int tn, input int rmem);
    logic [6:0] o;
    logic st_op;
    o = inst[6:0];
    st_op = (o == 7'b0100011);
    for (int i = 0; i < ((fd >= TO) ? TO : fd); i++)
      push(S_FETCH, 1'b0, $urandom, rb(), 1'b0, 1'b0);
    if (fd >= TO) begin trap_then_reset(2'd2, tn); return; end
    push(S_FETCH, 1'b1, inst, rb(), 1'b0, 1'b0);
    m_ir = inst;
    push(S_DECODE, rb(), $urandom, rb(), 1'b0, 1'b0);
    if (o == 7'b1110011) begin trap_then_reset(2'd1, tn); return; end
    if (!legal(o))       begin trap_then_reset(2'd0, tn); return; end
    push(S_EXEC, rb(), $urandom, rb(), 1'b0, 1'b0);
    if (o == 7'b0000011 || st_op) begin
      if (rmem >= 0) begin
        for (int i = 0; i <= rmem; i++) push(S_MEM, rb(), $urandom, 1'b0, 1'b0, st_op);
        reset_last();
        return;
      end
      for (int i = 0; i < ((md >= TO) ? TO : md); i++)
        push(S_MEM, rb(), $urandom, 1'b0, 1'b0, st_op);
      if (md >= TO) begin trap_then_reset(2'd3, tn); return; end
      push(S_MEM, rb(), $urandom, 1'b1, 1'b0, st_op);
    end
    push(S_WB, rb(), $urandom, rb(), writes_rd(o), 1'b0);
    m_instret = m_instret + 1'b1;
  endtask

  function automatic logic [31:0] rand_inst(input logic legal_only);
    logic [6:0]  ops[11];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
    r = $urandom;
    if (legal_only) return {r[31:7], ops[$urandom_range(9, 0)]};
    if ($urandom_range(7, 0) == 0) return r;
    return {r[31:7], ops[$urandom_range(10, 0)]};
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [11:0] act_ctl, exp_ctl;
    in_rst_n      = v.rst_n;
    in_imem_ready = v.irdy;
    in_imem_rdata = v.rdata;
    in_dmem_ready = v.drdy;
    #1;
    act_ctl = {out_state, out_imem_req, out_dmem_req, out_dmem_we & out_dmem_req,
               out_rf_we, out_pc_we, out_retire, out_trap, out_trap_cause};
    exp_ctl = {v.st, v.ireq, v.dreq, v.dwe, v.rf, v.pc, v.ret, v.trap, v.cause};
    checks++;
    if (act_ctl !== exp_ctl) begin
      errors++;
      $display("FAIL ctl cyc %0d: got st/ireq/dreq/we/rf/pc/ret/trap/cause=%b expected %b",
               idx, act_ctl, exp_ctl);
    end
    checks++;
    if (out_inst !== v.inst) begin
      errors++;
      $display("FAIL inst cyc %0d: got %h expected %h", idx, out_inst, v.inst);
    end
    checks++;
    if (out_instret !== v.instret) begin
      errors++;
      $display("FAIL instret cyc %0d: got %0d expected %0d", idx, out_instret, v.instret);
    end
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    // Hand-written: zero-wait ADDI, then SW with one dmem wait; spurious readies
    // outside request phases must be ignored (IR stays ADDI across DECODE/EXEC).
    tbl[0] = mk(1, 1, ADDI,          0, S_FETCH,  1, 0, 0, 0, 0, 0, 0, 0, NOP,  0);
    tbl[1] = mk(1, 1, 32'hDEADBEEF,  1, S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, ADDI, 0);
    tbl[2] = mk(1, 1, 32'h0000006F,  1, S_EXEC,   0, 0, 0, 0, 0, 0, 0, 0, ADDI, 0);
    tbl[3] = mk(1, 0, 0,             1, S_WB,     0, 0, 0, 1, 1, 1, 0, 0, ADDI, 0);
    tbl[4] = mk(1, 1, SW,            0, S_FETCH,  1, 0, 0, 0, 0, 0, 0, 0, ADDI, 1);
    tbl[5] = mk(1, 0, 0,             1, S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, SW,   1);
    tbl[6] = mk(1, 0, 0,             0, S_EXEC,   0, 0, 0, 0, 0, 0, 0, 0, SW,   1);
    tbl[7] = mk(1, 1, 32'hFFFFFFFF,  0, S_MEM,    0, 1, 1, 0, 0, 0, 0, 0, SW,   1);
    tbl[8] = mk(1, 0, 0,             1, S_MEM,    0, 1, 1, 0, 0, 0, 0, 0, SW,   1);
    tbl[9] = mk(1, 0, 0,             0, S_WB,     0, 0, 0, 0, 1, 1, 0, 0, SW,   1);
    m_ir = SW;
    m_instret = 2;

    gen(LW, 0, 2, 0, -1);                    // MEM lasts 3 cycles, 7 in total
    gen(SW, 1, 0, 0, -1);
    gen(32'h00000073, 0, 0, 21, -1);         // ECALL -> cause 1, then reset
    gen(32'hFFFFFFFF, 0, 0, 21, -1);         // illegal -> cause 0, then reset
    for (int i = 0; i < 3; i++) gen(ADDI, 0, 0, 0, -1);  // instret 3 from reset
    gen(ADDI, TO, 0, 3, -1);                 // fetch timeout -> cause 2
    gen(ADDI, TO - 1, 0, 0, -1);             // ready on last allowed cycle wins
    gen(LW, 0, TO, 3, -1);                   // dmem timeout -> cause 3
    gen(SW, 0, TO - 1, 0, -1);
    gen(LW, 0, 0, 0, 1);                     // reset during MEM wait
    gen(ADDI, 0, 0, 0, -1);
    for (int i = 0; i < 270; i++)            // long legal run wraps the 8-bit count
      gen(rand_inst(1'b1), $urandom_range(2, 0), $urandom_range(3, 0), 0, -1);
    for (int i = 0; i < 200; i++)
      gen(rand_inst(1'b0), ($urandom_range(15, 0) == 0) ? TO : $urandom_range(3, 0),
          ($urandom_range(15, 0) == 0) ? TO : $urandom_range(3, 0),
          $urandom_range(3, 1), -1);

    in_rst_n = 1'b0; in_imem_ready = 1'b0; in_imem_rdata = '0; in_dmem_ready = 1'b0;
    @(posedge in_clk); #1;
    @(posedge in_clk); #1;

    for (int i = 0; i < 10; i++) apply(tbl[i], i);
    for (int i = 0; i < q.size(); i++) apply(q[i], 10 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
